// File: rtl/cr16_ctrl_pkg.sv
// Shared encodings for the CR16 sequencer: FSM states, opcode/ext fields,
// condition codes, PSR flag positions and the instruction-class decoder.
package cr16_ctrl_pkg;

    localparam logic [2:0] ST_HALT   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;

    localparam logic [3:0] OP_BCOND  = 4'hC;
    localparam logic [3:0] OP_EXT    = 4'h4;
    localparam logic [3:0] EXT_JCOND = 4'hC;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    // PSR layout is {N,Z,F,L,C}
    localparam int unsigned FLAG_N = 4;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_C = 0;

    typedef struct packed {
        logic bcond;
        logic jcond;
        logic jal;
        logic load;
        logic stor;
        logic mem;
        logic alu;
    } dec_t;

    function automatic dec_t decode_ir(input logic [3:0] opcode, input logic [3:0] ext);
        dec_t d;
        d       = '0;
        d.bcond = (opcode == OP_BCOND);
        if (opcode == OP_EXT) begin
            d.jcond = (ext == EXT_JCOND);
            d.jal   = (ext == EXT_JAL);
            d.load  = (ext == EXT_LOAD);
            d.stor  = (ext == EXT_STOR);
        end
        d.mem = d.load | d.stor;
        d.alu = !(d.bcond | d.jcond | d.jal | d.mem);
        return d;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: 4-bit cond against PSR flags.
// Kept standalone so the Scond path can share it.
module cond_eval
    import cr16_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [4:0] flags_i,
    output logic       take_o
);

    logic n_f, z_f, f_f, l_f, c_f;

    assign n_f = flags_i[FLAG_N];
    assign z_f = flags_i[FLAG_Z];
    assign f_f = flags_i[FLAG_F];
    assign l_f = flags_i[FLAG_L];
    assign c_f = flags_i[FLAG_C];

    always_comb begin
        take_o = 1'b0;
        case (cond_i)
            CC_EQ:   take_o = z_f;
            CC_NE:   take_o = !z_f;
            CC_CS:   take_o = c_f;
            CC_CC:   take_o = !c_f;
            CC_HI:   take_o = l_f;
            CC_LS:   take_o = !l_f;
            CC_GT:   take_o = n_f;
            CC_LE:   take_o = !n_f;
            CC_FS:   take_o = f_f;
            CC_FC:   take_o = !f_f;
            CC_LO:   take_o = !l_f && !z_f;
            CC_HS:   take_o = l_f || z_f;
            CC_LT:   take_o = !n_f && !z_f;
            CC_GE:   take_o = n_f || z_f;
            CC_UC:   take_o = 1'b1;
            CC_NV:   take_o = 1'b0;
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_seq_ctrl.sv
// Multicycle CR16 instruction sequencer: fetch handshake, decode, condition
// evaluation, execute/memory strobes, PC controls and retired-instruction count.
module cr16_seq_ctrl
    import cr16_ctrl_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned CNTWIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 halt,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [DATAWIDTH-1:0] instr,
    output logic [DATAWIDTH-1:0] ir,
    input  logic [4:0]           flags,
    output logic                 exec_en,
    output logic                 rf_we,
    output logic                 mem_req,
    output logic                 mem_we,
    input  logic                 mem_ack,
    output logic                 pc_en,
    output logic                 branch,
    output logic                 jump,
    output logic                 ra_buf,
    output logic [CNTWIDTH-1:0]  instr_cnt,
    output logic                 busy
);

    logic [2:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] ir_q, ir_d;
    logic                 take_q, take_d;
    logic [CNTWIDTH-1:0]  cnt_q;

    logic                 take_c;
    logic                 pc_en_c;
    logic [2:0]           retire_next;
    dec_t                 dec;

    assign dec = decode_ir(ir_q[15:12], ir_q[7:4]);

    cond_eval u_cond_eval (
        .cond_i  (ir_q[11:8]),
        .flags_i (flags),
        .take_o  (take_c)
    );

    // halt only matters at the retire boundary; FETCH ignores it
    assign retire_next = halt ? ST_HALT : ST_FETCH;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        take_d  = take_q;
        case (state_q)
            ST_HALT: begin
                if (!halt) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                take_d  = take_c;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = dec.mem ? ST_MEM : retire_next;
            end
            ST_MEM: begin
                if (mem_ack) state_d = retire_next;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Strobes come from registered state/ir; only MEM looks at mem_ack directly
    always_comb begin
        imem_req = 1'b0;
        exec_en  = 1'b0;
        rf_we    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        pc_en_c  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
            end
            ST_EXEC: begin
                exec_en = 1'b1;
                rf_we   = dec.alu | dec.jal;
                pc_en_c = !dec.mem;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = dec.stor;
                pc_en_c = mem_ack;
                rf_we   = dec.load & mem_ack;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign pc_en     = pc_en_c;
    assign branch    = pc_en_c & dec.bcond & take_q;
    assign jump      = pc_en_c & ((dec.jcond & take_q) | dec.jal);
    assign ra_buf    = pc_en_c & dec.jal;
    assign ir        = ir_q;
    assign instr_cnt = cnt_q;
    assign busy      = (state_q != ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HALT;
            ir_q    <= '0;
            take_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            take_q  <= take_d;
            if (pc_en_c) cnt_q <= cnt_q + CNTWIDTH'(1);
        end
    end

endmodule
